// File: rtl/bnn_pkg.sv
// Shared BNN types and constants: popcount sample type, activation bit, popcount range.
package bnn_pkg;
  localparam int OL_DEF = 5;

  typedef logic signed [OL_DEF-1:0] pop_t;
  typedef logic act_t;

  localparam pop_t POP_MAX = 5'sd9;
  localparam pop_t POP_MIN = -5'sd9;
endpackage

// File: rtl/bnn_bin_thresh.sv
// Folded batch-norm binarizer: signed compare of a popcount against a threshold,
// direction flipped by iSIGN for a negative BN gamma.
module bnn_bin_thresh
  import bnn_pkg::*;
#(
  parameter int OL = OL_DEF
) (
  input  logic signed [OL-1:0] iDATA,
  input  logic signed [OL-1:0] iTHRESH,
  input  logic                 iSIGN,
  output act_t                 oBIT
);
  always_comb begin
    oBIT = iSIGN ? act_t'(iDATA <= iTHRESH) : act_t'(iDATA >= iTHRESH);
  end
endmodule

// File: rtl/bnn_bn_pool.sv
// Batch-norm threshold followed by 2x2 binary max-pool (OR) over a raster stream.
// Optional BNN_BN_POOL_BYPASS_EN adds iBYPASS to emit every thresholded bit unpooled.
module bnn_bn_pool
  import bnn_pkg::*;
#(
  parameter int OL    = OL_DEF,
  parameter int IMG_W = 12,
  parameter int IMG_H = 12
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iSTART,
  input  logic                 iVALID,
  input  logic signed [OL-1:0] iDATA,
  input  logic signed [OL-1:0] iTHRESH,
  input  logic                 iSIGN,
`ifdef BNN_BN_POOL_BYPASS_EN
  input  logic                 iBYPASS,
`endif
  output logic                 oVALID,
  output logic                 oDATA,
  output logic                 oDONE
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int HW = IMG_W / 2;
  localparam int BW = (HW > 1) ? $clog2(HW) : 1;

  if (((IMG_W % 2) != 0) || ((IMG_H % 2) != 0)) begin : g_param_err
    $error("bnn_bn_pool: IMG_W and IMG_H must both be even");
  end

  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic          pair_reg;
  logic          rowbuf_reg [HW];
  act_t          act;
  logic          bypass;
  logic          last_col;
  logic          last_row;
  logic [BW-1:0] buf_idx;

`ifdef BNN_BN_POOL_BYPASS_EN
  assign bypass = iBYPASS;
`else
  assign bypass = 1'b0;
`endif

  bnn_bin_thresh #(.OL(OL)) u_thresh (
    .iDATA   (iDATA),
    .iTHRESH (iTHRESH),
    .iSIGN   (iSIGN),
    .oBIT    (act)
  );

  assign last_col = (col_reg == CW'(IMG_W - 1));
  assign last_row = (row_reg == RW'(IMG_H - 1));
  assign buf_idx  = BW'(col_reg >> 1);

  // Row buffer is never read before the even row writes it, so it needs no reset.
  always_ff @(posedge iCLK) begin
    if (iRST && !iSTART && iVALID && col_reg[0] && !row_reg[0]) begin
      rowbuf_reg[buf_idx] <= pair_reg | act;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      col_reg  <= '0;
      row_reg  <= '0;
      pair_reg <= 1'b0;
      oVALID   <= 1'b0;
      oDATA    <= 1'b0;
      oDONE    <= 1'b0;
    end else if (iSTART) begin
      col_reg  <= '0;
      row_reg  <= '0;
      pair_reg <= 1'b0;
      oVALID   <= 1'b0;
      oDATA    <= 1'b0;
      oDONE    <= 1'b0;
    end else begin
      oVALID <= 1'b0;
      oDATA  <= 1'b0;
      oDONE  <= 1'b0;
      if (iVALID) begin
        col_reg <= last_col ? '0 : col_reg + 1'b1;
        if (last_col) begin
          row_reg <= last_row ? '0 : row_reg + 1'b1;
        end
        if (!col_reg[0]) begin
          pair_reg <= act;
        end
        if (bypass) begin
          oVALID <= 1'b1;
          oDATA  <= act;
          oDONE  <= last_col && last_row;
        end else if (col_reg[0] && row_reg[0]) begin
          oVALID <= 1'b1;
          oDATA  <= rowbuf_reg[buf_idx] | pair_reg | act;
          oDONE  <= last_col && last_row;
        end
      end
    end
  end
endmodule

// File: tb/tb_bnn_bn_pool.sv
// Directed self-checking bench for bnn_bn_pool and its bnn_bin_thresh sub-module.
`timescale 1ns/1ps
module tb_bnn_bn_pool;
  import bnn_pkg::*;

  logic iCLK = 1'b0;
  logic iRST, iSTART, iVALID, iSIGN;
  pop_t iDATA, iTHRESH;
  logic oVALID, oDATA, oDONE;
`ifdef BNN_BN_POOL_BYPASS_EN
  logic iBYPASS = 1'b0;
`endif

  pop_t th_d, th_t;
  logic th_s;
  act_t th_bit;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   orphan  = 0;
  logic beat_last = 1'b0;
  logic out_q[$];
  logic done_q[$];

  always #5 iCLK = ~iCLK;

  bnn_bn_pool dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iSTART  (iSTART),
    .iVALID  (iVALID),
    .iDATA   (iDATA),
    .iTHRESH (iTHRESH),
    .iSIGN   (iSIGN),
`ifdef BNN_BN_POOL_BYPASS_EN
    .iBYPASS (iBYPASS),
`endif
    .oVALID  (oVALID),
    .oDATA   (oDATA),
    .oDONE   (oDONE)
  );

  bnn_bin_thresh u_th (
    .iDATA   (th_d),
    .iTHRESH (th_t),
    .iSIGN   (th_s),
    .oBIT    (th_bit)
  );

  always @(posedge iCLK) beat_last = iVALID && !iSTART && iRST;

  always @(negedge iCLK) begin
    if (oVALID) begin
      out_q.push_back(oDATA);
      done_q.push_back(oDONE);
      if (!beat_last) orphan++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic int pix(input int kind, input int r, input int c);
    if (kind == 1) return (r == 5 && c == 8) ? 3 : -1;
    return 9;
  endfunction

  function automatic logic [35:0] pack_out(input int start);
    logic [35:0] v = '0;
    for (int i = 0; i < 36; i++)
      if (start + i < out_q.size()) v[i] = out_q[start + i];
    return v;
  endfunction

  function automatic logic [35:0] pack_done(input int start);
    logic [35:0] v = '0;
    for (int i = 0; i < 36; i++)
      if (start + i < done_q.size()) v[i] = done_q[start + i];
    return v;
  endfunction

  function automatic int count_ones(input int which);
    int n = 0;
    for (int i = 0; i < out_q.size(); i++)
      n += (which == 0) ? int'(out_q[i]) : int'(done_q[i]);
    return n;
  endfunction

  task automatic beat(input int v, input bit stall);
    int k = 0;
    if (stall) begin
      while ($urandom_range(0, 1) == 1 && k < 8) begin
        @(negedge iCLK);
        iVALID = 1'b0;
        k++;
      end
    end
    @(negedge iCLK);
    iVALID = 1'b1;
    iDATA  = pop_t'(v);
  endtask

  task automatic send_frame(input int kind, input bit stall, input int first, input int last_excl);
    for (int idx = first; idx < last_excl; idx++)
      beat(pix(kind, idx / 12, idx % 12), stall);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge iCLK);
      iVALID = 1'b0;
    end
  endtask

  task automatic clear_q();
    out_q.delete();
    done_q.delete();
  endtask

  logic [35:0] exp1;

  initial begin
    exp1 = '0;
    exp1[16] = 1'b1;
    iRST = 1'b0; iSTART = 1'b0; iVALID = 1'b0; iSIGN = 1'b0;
    iDATA = '0; iTHRESH = '0;
    #1;
    check("rst_valid", 64'(oVALID), 64'd0);
    check("rst_data",  64'(oDATA),  64'd0);
    check("rst_done",  64'(oDONE),  64'd0);

    th_t = 5'sd1; th_s = 1'b0;
    th_d = 5'sd1;   #1; check("th_s0_eq",   64'(th_bit), 64'd1);
    th_d = 5'sd0;   #1; check("th_s0_below", 64'(th_bit), 64'd0);
    th_d = POP_MIN; #1; check("th_s0_min",  64'(th_bit), 64'd0);
    th_d = POP_MAX; #1; check("th_s0_max",  64'(th_bit), 64'd1);
    th_s = 1'b1;
    th_d = 5'sd1;   #1; check("th_s1_eq",   64'(th_bit), 64'd1);
    th_d = 5'sd3;   #1; check("th_s1_above", 64'(th_bit), 64'd0);

    @(negedge iCLK);
    iRST = 1'b1;
    idle(2);

    clear_q();
    send_frame(1, 0, 0, 144);
    idle(3);
    check("pool_count", 64'(out_q.size()), 64'd36);
    check("pool_vec",   64'(pack_out(0)),  64'(exp1));
    check("pool_ones",  64'(count_ones(0)), 64'd1);
    check("pool_done",  64'(pack_done(0)), 64'(36'h1 << 35));

    clear_q();
    send_frame(1, 1, 0, 144);
    idle(3);
    check("stall_count", 64'(out_q.size()), 64'd36);
    check("stall_vec",   64'(pack_out(0)),  64'(exp1));
    check("stall_done",  64'(pack_done(0)), 64'(36'h1 << 35));

    clear_q();
    send_frame(1, 0, 0, 144);
    send_frame(2, 0, 0, 144);
    idle(3);
    check("b2b_count", 64'(out_q.size()), 64'd72);
    check("b2b_vec1",  64'(pack_out(0)),  64'(exp1));
    check("b2b_vec2",  64'(pack_out(36)), 64'hF_FFFF_FFFF);
    check("b2b_done1", 64'(pack_done(0)),  64'(36'h1 << 35));
    check("b2b_done2", 64'(pack_done(36)), 64'(36'h1 << 35));

    send_frame(2, 0, 0, 7 * 12 + 3);
    @(negedge iCLK);
    iVALID = 1'b0;
    #2 iRST = 1'b0;
    #1 check("rstmid_valid", 64'(oVALID), 64'd0);
    @(negedge iCLK);
    iRST = 1'b1;
    clear_q();
    send_frame(2, 0, 0, 13);
    idle(2);
    check("rstmid_early", 64'(out_q.size()), 64'd0);
    send_frame(2, 0, 13, 144);
    idle(3);
    check("rstmid_count", 64'(out_q.size()), 64'd36);
    check("rstmid_vec",   64'(pack_out(0)),  64'hF_FFFF_FFFF);
    check("rstmid_done",  64'(pack_done(0)), 64'(36'h1 << 35));

    send_frame(1, 0, 0, 4 * 12 + 6);
    @(negedge iCLK);
    iSTART = 1'b1;
    iVALID = 1'b1;
    iDATA  = 5'sd9;
    @(negedge iCLK);
    iSTART = 1'b0;
    iVALID = 1'b0;
    check("start_valid", 64'(oVALID), 64'd0);
    clear_q();
    send_frame(1, 0, 0, 144);
    idle(3);
    check("start_count", 64'(out_q.size()), 64'd36);
    check("start_vec",   64'(pack_out(0)),  64'(exp1));
    check("start_done",  64'(pack_done(0)), 64'(36'h1 << 35));

`ifdef BNN_BN_POOL_BYPASS_EN
    @(negedge iCLK);
    iSTART  = 1'b1;
    iBYPASS = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    clear_q();
    send_frame(1, 0, 0, 144);
    idle(3);
    check("byp_count", 64'(out_q.size()), 64'd144);
    check("byp_ones",  64'(count_ones(0)), 64'd1);
    check("byp_hit",   64'(out_q.size() > 68 ? out_q[68] : 1'b0), 64'd1);
    check("byp_done",  64'(count_ones(1)), 64'd1);
    iBYPASS = 1'b0;
`endif

    check("no_orphan", 64'(orphan), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
